// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants, flag bit positions and the
// packed result-buffer entry layout.
package alu_pkg;

  // ALU operation codes carried alongside each result
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_EQ  = 4'd8;
  localparam logic [3:0] OP_GT  = 4'd9;

  // Flag bit indices within the 3-bit {N,C,Z} vector
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

  localparam int RES_W  = 16;
  localparam int SEL_W  = 4;
  localparam int FLAG_W = 3;

  // One buffered ALU result
  typedef struct packed {
    logic [RES_W-1:0]  result;
    logic [SEL_W-1:0]  sel;
    logic [FLAG_W-1:0] flags;
  } alu_entry_t;

  localparam int ENTRY_W = $bits(alu_entry_t);

endpackage

// File: rtl/alu_res_fifo.sv
// Storage array with wrap-around read/write pointers and an occupancy
// counter. The head read is masked to zero while empty so stale array
// contents never leak out; the array itself is intentionally not reset.
module alu_res_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  alu_entry_t    wr_data,
  output alu_entry_t    rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  alu_entry_t          mem [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q,  count_d;
  logic                push_ok, pop_ok;

  // Qualify requests against current occupancy so callers cannot corrupt state
  always_comb begin
    full    = (count_q == FULL_CNT);
    empty   = (count_q == '0);
    push_ok = push && !full;
    pop_ok  = pop && !empty;
  end

  // Next pointer / count; power-of-two depth makes natural overflow the wrap
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count state, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wr_data;
  end

  // Head entry, forced to zero while nothing is stored
  always_comb begin
    rd_data = '0;
    if (!empty) rd_data = mem[rd_ptr_q];
  end

  assign count = count_q;

endmodule

// File: rtl/alu_result_buffer.sv
// ALU result buffer: valid/ready FIFO of {result, sel, flags} entries with
// an optional sticky OR of the flags of every accepted entry.
// Optional feature macro: ALU_RESULT_BUFFER_STICKY_EN (sticky flag register).
// Without it sticky_flags reads 3'b000 and sticky_clr has no effect.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              in_result,
  input  logic [3:0]               in_sel,
  input  logic [2:0]               in_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_result,
  output logic [3:0]               out_sel,
  output logic [2:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     sticky_clr,
  output logic [2:0]               sticky_flags
);

  localparam int CW = $clog2(DEPTH) + 1;

  alu_entry_t    wr_entry;
  alu_entry_t    rd_entry;
  logic          fifo_full, fifo_empty;
  logic          push, pop;
  logic [CW-1:0] fifo_count;

  // Handshakes depend only on registered occupancy, never on out_ready
  always_comb begin
    in_ready  = !fifo_full;
    out_valid = !fifo_empty;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Pack incoming fields and unpack the head entry
  always_comb begin
    wr_entry.result = in_result;
    wr_entry.sel    = in_sel;
    wr_entry.flags  = in_flags;
    out_result      = rd_entry.result;
    out_sel         = rd_entry.sel;
    out_flags       = rd_entry.flags;
    count           = fifo_count;
  end

  alu_res_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef ALU_RESULT_BUFFER_STICKY_EN
  logic [2:0] sticky_q, sticky_d;

  // Clear takes priority, then the pushed flags accumulate on top
  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr) sticky_d = '0;
    if (push)       sticky_d = sticky_d | in_flags;
  end

  // Sticky flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= '0;
    else     sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_flags      = 3'b000;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer (DEPTH=4): directed scenarios
// plus randomized traffic compared each cycle against a queue-based model.
module tb_alu_result_buffer;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_result = '0;
  logic [3:0]  in_sel = '0;
  logic [2:0]  in_flags = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic [3:0]  out_sel;
  logic [2:0]  out_flags;
  logic [2:0]  count;
  logic        sticky_clr = 1'b0;
  logic [2:0]  sticky_flags;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of entries plus sticky accumulator
  alu_entry_t mq[$];
  logic [2:0] m_sticky = '0;

  always #5 clk = ~clk;

  alu_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_sel(in_sel), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_sel(out_sel), .out_flags(out_flags),
    .count(count), .sticky_clr(sticky_clr), .sticky_flags(sticky_flags)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge
  task automatic cyc();
    bit p, o;
    alu_entry_t e;
    p = in_valid && (mq.size() < DEPTH);
    o = out_ready && (mq.size() > 0);
    e.result = in_result; e.sel = in_sel; e.flags = in_flags;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_sticky = '0;
    end else begin
      if (o) void'(mq.pop_front());
      if (p) mq.push_back(e);
`ifdef ALU_RESULT_BUFFER_STICKY_EN
      if (sticky_clr) m_sticky = '0;
      if (p) m_sticky = m_sticky | e.flags;
`endif
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mq.delete();
    m_sticky = '0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_out_result", {16'b0, out_result}, 32'd0);
    chk("rst_sticky", {29'b0, sticky_flags}, 32'd0);
    cyc();
    rst = 1'b0;
  endtask

  task automatic drive(input bit v, input logic [15:0] r, input logic [3:0] s,
                       input logic [2:0] f, input bit rdy, input bit clr);
    in_valid = v; in_result = r; in_sel = s; in_flags = f;
    out_ready = rdy; sticky_clr = clr;
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    alu_entry_t h;
    h = (mq.size() > 0) ? mq[0] : '0;
    chk("cyc_out_valid", {31'b0, out_valid}, {31'b0, mq.size() > 0});
    chk("cyc_in_ready", {31'b0, in_ready}, {31'b0, mq.size() < DEPTH});
    chk("cyc_count", {29'b0, count}, mq.size());
    chk("cyc_head", {9'b0, out_result, out_sel, out_flags}, {9'b0, h});
    chk("cyc_sticky", {29'b0, sticky_flags}, {29'b0, m_sticky});
  end

  logic [2:0] exp_s;
  logic [15:0] d;

  initial begin
    do_reset();

    // Single push: visible one cycle later
    drive(1, 16'h0005, OP_ADD, 3'b000, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    chk("p1_valid", {31'b0, out_valid}, 32'd1);
    chk("p1_result", {16'b0, out_result}, 32'h5);
    chk("p1_count", {29'b0, count}, 32'd1);
    drive(0, 0, 0, 0, 1, 0);
    cyc();
    chk("p1_empty_zero", {16'b0, out_result}, 32'd0);

    // Overfill: 5 pushes with no pops
    for (int i = 1; i <= 5; i++) begin
      drive(1, 16'(i), OP_SUB, 3'b000, 0, 0);
      cyc();
      if (i == 3) chk("fill_ready3", {31'b0, in_ready}, 32'd1);
      if (i == 4) chk("fill_ready4", {31'b0, in_ready}, 32'd0);
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("fill_count", {29'b0, count}, 32'd4);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 0, 1, 0);
      chk("drain_val", {16'b0, out_result}, i);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("drain_empty", {31'b0, out_valid}, 32'd0);

    // Steady streaming at count 2 across pointer wrap
    for (int i = 0; i < 2; i++) begin
      drive(1, 16'h100 + 16'(i), OP_OR, 3'b000, 0, 0);
      cyc();
    end
    for (int i = 2; i < 12; i++) begin
      drive(1, 16'h100 + 16'(i), OP_XOR, 3'b000, 1, 0);
      chk("stream_head", {16'b0, out_result}, 32'h100 + i - 2);
      cyc();
      chk("stream_count", {29'b0, count}, 32'd2);
    end
    drive(0, 0, 0, 0, 1, 0);
    cyc(); cyc();
    drive(0, 0, 0, 0, 0, 0);

    // Sticky accumulate and clear-with-push
    drive(0, 0, 0, 0, 0, 1);
    cyc();
    drive(1, 16'h11, OP_EQ, 3'b001, 1, 0);
    cyc();
    drive(1, 16'h22, OP_GT, 3'b010, 1, 0);
    cyc();
    drive(0, 0, 0, 0, 1, 0);
`ifdef ALU_RESULT_BUFFER_STICKY_EN
    exp_s = 3'b011;
`else
    exp_s = 3'b000;
`endif
    chk("sticky_acc", {29'b0, sticky_flags}, {29'b0, exp_s});
    drive(1, 16'h33, OP_SHL, 3'b100, 1, 1);
    cyc();
`ifdef ALU_RESULT_BUFFER_STICKY_EN
    exp_s = 3'b100;
`else
    exp_s = 3'b000;
`endif
    chk("sticky_clrpush", {29'b0, sticky_flags}, {29'b0, exp_s});
    chk("sticky_fifo_head", {16'b0, out_result}, 32'h33);
    drive(0, 0, 0, 0, 1, 0);
    cyc(); cyc();

    // Reset mid-drain with 3 entries held
    for (int i = 0; i < 4; i++) begin
      drive(1, 16'hA0 + 16'(i), OP_AND, 3'b000, 0, 0);
      cyc();
    end
    drive(0, 0, 0, 0, 1, 0);
    cyc();
    chk("pre_rst_count", {29'b0, count}, 32'd3);
    do_reset();
    drive(1, 16'hBEEF, OP_NOT, 3'b000, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 1, 0);
    chk("post_rst_head", {16'b0, out_result}, 32'hBEEF);
    cyc();
    chk("post_rst_empty", {31'b0, out_valid}, 32'd0);

    // Randomized traffic with occasional clears and resets
    for (int i = 0; i < 3000; i++) begin
      d = 16'($urandom);
      drive($urandom_range(0, 3) != 0, d, 4'($urandom_range(0, 9)),
            3'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) begin
        drive(0, 0, 0, 0, 0, 0);
        do_reset();
      end else begin
        cyc();
      end
    end

    drive(0, 0, 0, 0, 0, 0);
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of result entries; power of two, 2..16.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  upstream ALU result present this cycle.
REQ-005 Port: in_ready  output  1  buffer can accept an entry this cycle.
REQ-006 Port: in_result  input  16  ALU result word.
REQ-007 Port: in_sel  input  4  ALU operation code that produced in_result.
REQ-008 Port: in_flags  input  3  ALU flags {Negative, Carry, Zero}, bit 2 = Negative, bit 0 = Zero.
REQ-009 Port: out_valid  output  1  head entry available.
REQ-010 Port: out_ready  input  1  downstream accepts the head entry.
REQ-011 Port: out_result / out_sel / out_flags  output  16/4/3  fields of the head entry.
REQ-012 Port: count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-013 Port: sticky_clr  input  1  clears sticky flags.
REQ-014 Port: sticky_flags  output  3  OR-accumulated {N,C,Z} of all accepted entries since the last clear.

Function
REQ-015 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-016 in_ready SHALL be 1 exactly when count < DEPTH; it is registered-state-derived only, with no combinational path from out_ready.
REQ-017 out_valid SHALL be 1 exactly when count > 0; there is no bypass, so a push into an empty buffer is visible at the outputs on the cycle after the push edge.
REQ-018 Entries SHALL leave in push order; out_* fields SHALL hold stable while out_valid && !out_ready.
REQ-019 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
REQ-020 Full (count == DEPTH): in_ready = 0; in_valid is ignored, no entry is written, and no error is raised; a pop in that cycle frees one slot for the next cycle.
REQ-021 Empty: out_* data fields SHALL read 0; out_ready is ignored.
REQ-022 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-023 Sticky update on each push: sticky_flags <= sticky_flags | in_flags.
REQ-024 sticky_clr without a push: sticky_flags <= 0. sticky_clr with a simultaneous push: sticky_flags <= in_flags (clear first, then accumulate).

Reset
REQ-025 While rst = 1, the following SHALL be forced asynchronously: count = 0, both pointers = 0, out_valid = 0, in_ready = 1, out_result/out_sel/out_flags = 0, sticky_flags = 0.
REQ-026 Reset asserted mid-transfer SHALL discard all stored entries; the first push after deassertion is entry 0.
REQ-027 The storage array need not be reset; its contents SHALL never be observable while the buffer is empty.

Configuration
REQ-028 Macro ALU_RESULT_BUFFER_STICKY_EN defined: REQ-023/024 behaviour is compiled in.
REQ-029 Macro not defined: no sticky register is generated, sticky_flags is tied to 3'b000, sticky_clr is unused, and all other behaviour is identical.

Structure
REQ-030 Shared package alu_pkg SHALL hold the ALU opcode constants (ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, SHL=6, SHR=7, EQ=8, GT=9), the flag bit indices (Z=0, C=1, N=2), and the packed entry typedef {result[15:0], sel[3:0], flags[2:0]}.
REQ-031 One sub-module, alu_res_fifo (storage array plus pointers plus count), SHALL be instantiated; sticky logic and port mapping remain in the top level.

Verification
REQ-032 Reset, then push {0x0005, ADD, 3'b000}; out_valid rises 1 cycle later, out_result = 0x0005, count = 1.
REQ-033 DEPTH=4, out_ready = 0: push 5 consecutive entries 1..5; in_ready falls after the 4th; the 5th is not stored; count = 4; draining yields 1, 2, 3, 4.
REQ-034 count = 2, in_valid = out_ready = 1 held for 10 cycles with incrementing data: count stays 2, order is preserved, and pointers wrap without loss.
REQ-035 Sticky enabled: push flags 3'b001, then 3'b010 -> sticky = 3'b011; sticky_clr together with a push of 3'b100 -> sticky = 3'b100.
REQ-036 Assert rst with count = 3 mid-drain -> immediately out_valid = 0, count = 0, in_ready = 1; after deassertion, a push of 0xBEEF is the first value popped.
REQ-037 Build without ALU_RESULT_BUFFER_STICKY_EN and repeat REQ-035 stimulus -> sticky_flags stays 3'b000 and FIFO results are unchanged.
